dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter that shares the single-port word-addressed data memory (comb read, sync write, DEPTH words) between the CPU load/store path (port 0) and a debug/loader port (port 1).
- Grants at most one access per cycle, drives the RAM address, write-enable and data pins, and returns registered completion, read data and range error to the winner.
- Sits between the datapath/loader and the RAM instance in the top level.

Parameters:
- DEPTH, 128, RAM depth in 32-bit words; legal word index is 0..DEPTH-1.
- WIDTH, 32, data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held with we0/adr0/din0 stable until gnt0.
- we0  in  1  port 0 write (1) / read (0).
- adr0  in  32  port 0 byte address; bits [1:0] ignored.
- din0  in  WIDTH  port 0 write data.
- gnt0  out  1  combinational grant; the access completes at the edge ending this cycle.
- rvalid0  out  1  registered completion pulse, one cycle after the gnt0 cycle.
- rdata0  out  WIDTH  registered read data, valid when rvalid0 and read.
- err0  out  1  registered, with rvalid0: word index out of range.
- req1, we1, adr1, din1, gnt1, rvalid1, rdata1, err1: same as port 0, for port 1.
- ram_we  out  1  RAM write enable.
- ram_adr  out  32  RAM byte address (winner's adr, passed through).
- ram_din  out  WIDTH  RAM write data.
- ram_dout  in  WIDTH  RAM combinational read data.

Behaviour:
- State:
  - prio: 1 bit, preferred port; reset value 0.
  - rvalid0/1, err0/1: reset value 0.
  - rdata0/1: reset value 0.
- Arbitration (combinational):
  - Only one request asserted: that port wins.
  - Both asserted: port == prio wins.
  - Neither asserted: no grant.
- gntN is high only for the winner. gnt0 & gnt1 is never 1. Both grants are 0 while reset is high.
- prio update: on each edge where a grant occurs, prio <= the loser index (1 - winner). With no grant, prio holds. Two continuously requesting ports therefore alternate 0,1,0,1.
- RAM drive:
  - ram_adr and ram_din: winner's adr and din. With no grant, port 0's values (don't care).
  - ram_we = gnt & we_winner & in_range & ~reset.
- in_range: adr[31:2] < DEPTH; compare the full 30-bit index, no truncation.
- Out-of-range access: granted normally, but the write is suppressed and no RAM read is used. At the next cycle rvalidN=1, errN=1, and rdataN holds its previous value.
- Completion, at the edge ending a gntN cycle:
  - rvalidN <= 1.
  - errN <= ~in_range.
  - rdataN <= ram_dout only if read and in range; otherwise rdataN holds.
  - Write completions leave rdataN unchanged.
- rvalidN/errN fall to 0 on the next edge unless port N is granted again. Back-to-back grants to the same port give rvalid high on consecutive cycles.
- Latency: a read issued alone is granted in the same cycle, with data 1 cycle later. The losing port waits exactly 1 cycle under contention.
- Requester may drop req or present a new request in the cycle after gnt. A held req after gnt is a new transaction.
- Reset mid-operation (async): all registers clear immediately; any grant in progress is aborted, with no write and no rvalid. After reset release, arbitration resumes with prio=0.
- Write-then-read, same address, consecutive grants: the read returns the newly written value (RAM write at edge, comb read next cycle).

Test Plan:
- Reset, idle: reset=1 -> gnt0=gnt1=0, ram_we=0, all rvalid/err=0, rdata=0. Release -> prio=0.
- Single read: memory[5]=0xDEADBEEF; req0=1, we0=0, adr0=0x14 -> gnt0=1 same cycle; next cycle rvalid0=1, rdata0=0xDEADBEEF, err0=0.
- Contention: req0=req1=1, both reads, for 4 cycles from reset -> grant order 0,1,0,1; each rvalid follows its grant by 1 cycle; gnt0&gnt1 never 1.
- Write/read-back: port 1 writes 0x12345678 to adr 0x1FC (index 127), then reads 0x1FC -> ram_we=1 only in the write cycle; the read returns 0x12345678; rdata1 unchanged after the write completion.
- Out of range: port 0 writes adr 0x200 (index 128) with din 0xFFFFFFFF -> ram_we=0; next cycle rvalid0=1, err0=1; memory unchanged; rdata0 unchanged.
- Async reset mid-write: assert reset between edges while gnt0 & we0 -> ram_we drops immediately; the target word keeps its old value; no rvalid0 after release; prio=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port round-robin arbiter that shares a single-port, word-addressed
//   data RAM (combinational read, synchronous write, DEPTH words) between
//   the CPU load/store path (port 0) and a debug/loader port (port 1).
//
// Ports
//   clk, reset            : system clock, asynchronous active-high reset
//   reqN/weN/adrN/dinN    : port N request, write flag, byte address, data
//   gntN                  : combinational grant, access completes this cycle
//   rvalidN/rdataN/errN   : registered completion, read data, range error
//   ram_we/ram_adr/ram_din: RAM write enable, byte address, write data
//   ram_dout              : RAM combinational read data
module dmem_arbiter #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [31:0]      adr0,
  input  logic [WIDTH-1:0] din0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [WIDTH-1:0] rdata0,
  output logic             err0,
  input  logic             req1,
  input  logic             we1,
  input  logic [31:0]      adr1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata1,
  output logic             err1,
  output logic             ram_we,
  output logic [31:0]      ram_adr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  typedef enum logic {
    PRIO_P0 = 1'b0,
    PRIO_P1 = 1'b1
  } prio_e;

  prio_e            prio_q,    prio_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             err0_q,    err0_d;
  logic             err1_q,    err1_d;
  logic [WIDTH-1:0] rdata0_q,  rdata0_d;
  logic [WIDTH-1:0] rdata1_q,  rdata1_d;

  logic in_range0;
  logic in_range1;
  logic win0;
  logic win1;

  // Full 30-bit word index is compared; high address bits must not alias
  // back into the array.
  always_comb begin
    in_range0 = ({2'b00, adr0[31:2]} < 32'(DEPTH));
    in_range1 = ({2'b00, adr1[31:2]} < 32'(DEPTH));
  end

  // Arbitration: a lone requester wins; on contention the preferred port
  // wins. Grants are suppressed while reset is held so an access in flight
  // is aborted immediately.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        win0 = (prio_q == PRIO_P0);
        win1 = (prio_q == PRIO_P1);
      end else begin
        win0 = req0;
        win1 = req1;
      end
    end
    gnt0 = win0;
    gnt1 = win1;
  end

  // RAM drive: port 0 values pass through when nobody is granted.
  always_comb begin
    ram_adr = adr0;
    ram_din = din0;
    ram_we  = 1'b0;
    if (win1) begin
      ram_adr = adr1;
      ram_din = din1;
      ram_we  = we1 & in_range1;
    end else if (win0) begin
      ram_we  = we0 & in_range0;
    end
    ram_we = ram_we & ~reset;
  end

  // Next-state: the loser of a grant becomes preferred; completion status
  // is a one-cycle pulse; read data updates only for in-range reads.
  always_comb begin
    prio_d    = prio_q;
    rvalid0_d = win0;
    rvalid1_d = win1;
    err0_d    = win0 & ~in_range0;
    err1_d    = win1 & ~in_range1;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (win0) begin
      prio_d = PRIO_P1;
      if (!we0 && in_range0) rdata0_d = ram_dout;
    end
    if (win1) begin
      prio_d = PRIO_P0;
      if (!we1 && in_range1) rdata1_d = ram_dout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q    <= PRIO_P0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    rvalid0 = rvalid0_q;
    rvalid1 = rvalid1_q;
    err0    = err0_q;
    err1    = err1_q;
    rdata0  = rdata0_q;
    rdata1  = rdata1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a table of one-cycle vectors with
// hand-computed grant/RAM-enable and completion values, plus a hand-written
// asynchronous-reset-during-write sequence. A behavioural RAM sits on the
// RAM pins.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] adr0, din0, adr1, din1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        ram_we;
  logic [31:0] ram_adr, ram_din, ram_dout;

  logic [31:0] mem [0:127];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(128), .WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .adr0(adr0), .din0(din0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .adr1(adr1), .din1(din1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Behavioural RAM; out-of-range addresses alias so that a wrongly used
  // read or write would be visible.
  assign ram_dout = mem[ram_adr[8:2]];
  always @(posedge clk) if (ram_we) mem[ram_adr[8:2]] <= ram_din;

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, we;
    logic        v0, e0;
    logic [31:0] q0;
    logic        v1, e1;
    logic [31:0] q1;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic rst,
    input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
    input logic g0, input logic g1, input logic we,
    input logic v0, input logic e0, input logic [31:0] q0,
    input logic v1, input logic e1, input logic [31:0] q1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.we = we;
    v.v0 = v0; v.e0 = e0; v.q0 = q0; v.v1 = v1; v.e1 = e1; v.q1 = q1;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = i * 32'h0101_0101;
    mem[5] = 32'hDEAD_BEEF;

    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h14; din0 = 32'h1111_1111;
    req1 = 1'b1; we1 = 1'b0; adr1 = 32'h18; din1 = '0;

    //          rst r0 w0 a0            d0            r1 w1 a1       d1            g0 g1 we  v0 e0 q0            v1 e1 q1
    vecs.push_back(mk(0, 0,0,32'h0,        32'h0,        0,0,32'h0,   32'h0,        0,0,0,  0,0,32'h0,        0,0,32'h0));
    vecs.push_back(mk(0, 1,0,32'h14,       32'h0,        0,0,32'h0,   32'h0,        1,0,0,  1,0,32'hDEADBEEF, 0,0,32'h0));
    vecs.push_back(mk(0, 0,0,32'h0,        32'h0,        0,0,32'h0,   32'h0,        0,0,0,  0,0,32'hDEADBEEF, 0,0,32'h0));
    vecs.push_back(mk(1, 1,0,32'h14,       32'h0,        1,0,32'h18,  32'h0,        0,0,0,  0,0,32'h0,        0,0,32'h0));
    vecs.push_back(mk(0, 1,0,32'h14,       32'h0,        1,0,32'h18,  32'h0,        1,0,0,  1,0,32'hDEADBEEF, 0,0,32'h0));
    vecs.push_back(mk(0, 1,0,32'h14,       32'h0,        1,0,32'h18,  32'h0,        0,1,0,  0,0,32'hDEADBEEF, 1,0,32'h06060606));
    vecs.push_back(mk(0, 1,0,32'h14,       32'h0,        1,0,32'h18,  32'h0,        1,0,0,  1,0,32'hDEADBEEF, 0,0,32'h06060606));
    vecs.push_back(mk(0, 1,0,32'h14,       32'h0,        1,0,32'h18,  32'h0,        0,1,0,  0,0,32'hDEADBEEF, 1,0,32'h06060606));
    vecs.push_back(mk(0, 0,0,32'h0,        32'h0,        1,1,32'h1FC, 32'h12345678, 0,1,1,  0,0,32'hDEADBEEF, 1,0,32'h06060606));
    vecs.push_back(mk(0, 0,0,32'h0,        32'h0,        1,0,32'h1FC, 32'h0,        0,1,0,  0,0,32'hDEADBEEF, 1,0,32'h12345678));
    vecs.push_back(mk(0, 1,1,32'h200,      32'hFFFFFFFF, 0,0,32'h0,   32'h0,        1,0,0,  1,1,32'hDEADBEEF, 0,0,32'h12345678));
    vecs.push_back(mk(0, 1,0,32'h200,      32'h0,        0,0,32'h0,   32'h0,        1,0,0,  1,1,32'hDEADBEEF, 0,0,32'h12345678));
    vecs.push_back(mk(0, 1,0,32'h80000014, 32'h0,        0,0,32'h0,   32'h0,        1,0,0,  1,1,32'hDEADBEEF, 0,0,32'h12345678));
    vecs.push_back(mk(0, 1,0,32'h1FC,      32'h0,        0,0,32'h0,   32'h0,        1,0,0,  1,0,32'h12345678, 0,0,32'h12345678));
    vecs.push_back(mk(0, 1,0,32'h14,       32'h0,        1,0,32'h0,   32'h0,        0,1,0,  0,0,32'h12345678, 1,0,32'h0));
    vecs.push_back(mk(0, 1,0,32'h14,       32'h0,        1,0,32'h0,   32'h0,        1,0,0,  1,0,32'hDEADBEEF, 0,0,32'h0));

    // Reset state with both ports requesting.
    #2;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rst_err", {30'd0, err1, err0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      req0 = vecs[i].r0; we0 = vecs[i].w0; adr0 = vecs[i].a0; din0 = vecs[i].d0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; adr1 = vecs[i].a1; din1 = vecs[i].d1;
      #2;
      chk($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
      chk($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].we));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rvalid0", i), 32'(rvalid0), 32'(vecs[i].v0));
      chk($sformatf("v%0d_err0", i), 32'(err0), 32'(vecs[i].e0));
      chk($sformatf("v%0d_rdata0", i), rdata0, vecs[i].q0);
      chk($sformatf("v%0d_rvalid1", i), 32'(rvalid1), 32'(vecs[i].v1));
      chk($sformatf("v%0d_err1", i), 32'(err1), 32'(vecs[i].e1));
      chk($sformatf("v%0d_rdata1", i), rdata1, vecs[i].q1);
    end

    // Memory effects of the table: in-range write landed, out-of-range
    // write (0x200 aliases word 0 in the model) did not.
    chk("mem127", mem[127], 32'h12345678);
    chk("mem0_untouched", mem[0], 32'h0);

    // Asynchronous reset asserted between edges during a port 0 write.
    reset = 1'b0;
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h28; din0 = 32'hCAFEF00D;
    #2;
    chk("ar_gnt0_before", 32'(gnt0), 32'd1);
    chk("ar_we_before", 32'(ram_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_gnt0_during", 32'(gnt0), 32'd0);
    chk("ar_we_during", 32'(ram_we), 32'd0);
    chk("ar_rdata0_cleared", rdata0, 32'd0);
    @(posedge clk); #1;
    chk("ar_mem10", mem[10], 32'h0A0A0A0A);
    req0 = 1'b0; we0 = 1'b0;
    #4;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ar_no_rvalid0", 32'(rvalid0), 32'd0);
    chk("ar_mem10_after", mem[10], 32'h0A0A0A0A);
    // prio must be 0 again: contention goes to port 0.
    req0 = 1'b1; adr0 = 32'h28; req1 = 1'b1; adr1 = 32'h14;
    #2;
    chk("ar_prio_gnt0", 32'(gnt0), 32'd1);
    chk("ar_prio_gnt1", 32'(gnt1), 32'd0);
    @(posedge clk); #1;
    chk("ar_read_rdata0", rdata0, 32'h0A0A0A0A);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
